// File: rtl/serial_mag_cmp_ctrl_pkg.sv
// serial_mag_cmp_ctrl_pkg: state encodings and count-width helper for the serial comparator
package serial_mag_cmp_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_mag_cmp_ctrl_if.sv
// serial_mag_cmp_ctrl_if: requester-side handshake, operands and registered results
interface serial_mag_cmp_ctrl_if
  import serial_mag_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CNT_W = cnt_width(WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic gt;
  logic lt;
  logic eq;
  logic [CNT_W-1:0] nbits;
  modport master(output start, a, b, input busy, done, gt, lt, eq, nbits);
  modport slave(input start, a, b, output busy, done, gt, lt, eq, nbits);
endinterface

// File: rtl/serial_mag_cmp_ctrl_mag_cmp_1b.sv
// mag_cmp_1b: combinational single-bit magnitude comparator cell
module mag_cmp_1b (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);
  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);
endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// serial_mag_cmp_ctrl: MSB-first bit-serial magnitude compare with early exit on first differing bit
module serial_mag_cmp_ctrl
  import serial_mag_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_mag_cmp_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CNT_W-1:0] idx, cnt;
  logic bit_a, bit_b, c_gt, c_lt, c_eq, fin;
  assign bit_a = 1'(a_r >> idx);
  assign bit_b = 1'(b_r >> idx);
  mag_cmp_1b u_cell (.a(bit_a), .b(bit_b), .gt(c_gt), .lt(c_lt), .eq(c_eq));
  // a differing bit ends the walk early; bit 0 always ends it
  assign fin = c_gt | c_lt | (idx == '0);
  always_comb begin
    state_n = ST_IDLE;
    state_n = (state == ST_IDLE) ? (bus.start ? ST_COMPARE : ST_IDLE) :
              (state == ST_COMPARE) ? (fin ? ST_DONE : ST_COMPARE) : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= CNT_W'(WIDTH - 1);
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.gt <= 1'b0;
      bus.lt <= 1'b0;
      bus.eq <= 1'b0;
      bus.nbits <= '0;
    end else begin
      state <= state_n;
      bus.busy <= (state_n != ST_IDLE);
      bus.done <= (state_n == ST_DONE);
      if (state == ST_IDLE && bus.start) begin
        a_r <= bus.a;
        b_r <= bus.b;
        idx <= CNT_W'(WIDTH - 1);
        cnt <= '0;
      end
      if (state == ST_COMPARE) begin
        cnt <= cnt + CNT_W'(1);
        if (fin) begin
          bus.gt <= c_gt;
          bus.lt <= c_lt;
          bus.eq <= c_eq;
          bus.nbits <= cnt + CNT_W'(1);
        end else begin
          idx <= idx - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// tb_serial_mag_cmp_ctrl: directed and random checks of the serial comparator against an arithmetic model
module tb_serial_mag_cmp_ctrl;
  localparam int WIDTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic e_gt = 1'b0, e_lt = 1'b0, e_eq = 1'b0;
  int e_nb = 0;
  serial_mag_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();
  serial_mag_cmp_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // bits examined = WIDTH minus index of highest differing bit, or WIDTH when equal
  function automatic int ref_n(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    for (int i = WIDTH - 1; i >= 0; i--) if (x[i] != y[i]) return WIDTH - i;
    return WIDTH;
  endfunction
  task automatic chk_res(input string tag);
    chk({tag, "_gt"}, bus.gt, e_gt);
    chk({tag, "_lt"}, bus.lt, e_lt);
    chk({tag, "_eq"}, bus.eq, e_eq);
    chk({tag, "_nbits"}, bus.nbits, e_nb);
  endtask
  // called at the negedge just after the accepting edge, start already dropped
  task automatic finish_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input string tag);
    int n = ref_n(xa, xb);
    int m = 0;
    chk({tag, "_busy"}, bus.busy, 1);
    while (!bus.done && m < WIDTH + 3) begin
      chk({tag, "_hold"}, {bus.gt, bus.lt, bus.eq}, {e_gt, e_lt, e_eq});
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      @(negedge clk);
      m++;
    end
    chk({tag, "_latency"}, m, n);
    e_gt = xa > xb;
    e_lt = xa < xb;
    e_eq = xa == xb;
    e_nb = n;
    chk_res(tag);
    @(negedge clk);
    chk({tag, "_done_off"}, bus.done, 0);
    chk({tag, "_busy_off"}, bus.busy, 0);
    chk_res({tag, "_held"});
  endtask
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input string tag);
    @(negedge clk);
    bus.a = xa;
    bus.b = xb;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op(xa, xb, tag);
  endtask
  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus.start = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk_res("rst");
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op('0, '0, "rst_accept");
    do_op(8'hA5, 8'h25, "t2");
    do_op(8'h3C, 8'h3D, "t3");
    do_op(8'h5A, 8'h5A, "t4");
    @(negedge clk);
    bus.a = 8'h80;
    bus.b = 8'h7F;
    bus.start = 1'b1;
    @(negedge clk);
    chk("t5_busy", bus.busy, 1);
    chk("t5_done0", bus.done, 0);
    @(negedge clk);
    e_gt = 1'b1; e_lt = 1'b0; e_eq = 1'b0; e_nb = 1;
    chk("t5_done1", bus.done, 1);
    chk_res("t5_first");
    bus.a = 8'h00;
    bus.b = 8'hFF;
    @(negedge clk);
    chk("t5_gap_done", bus.done, 0);
    chk("t5_gap_busy", bus.busy, 0);
    @(negedge clk);
    chk("t5_busy2", bus.busy, 1);
    chk("t5_nodone2", bus.done, 0);
    bus.start = 1'b0;
    @(negedge clk);
    e_gt = 1'b0; e_lt = 1'b1; e_eq = 1'b0; e_nb = 1;
    chk("t5_done2", bus.done, 1);
    chk_res("t5_second");
    @(negedge clk);
    chk("t5_done2_off", bus.done, 0);
    @(negedge clk);
    bus.a = 8'h01;
    bus.b = 8'h00;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_pre_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0; e_nb = 0;
    chk("t6_abort_busy", bus.busy, 0);
    chk("t6_abort_done", bus.done, 0);
    chk_res("t6_abort");
    repeat (2) begin
      @(negedge clk);
      chk("t6_rst_done", bus.done, 0);
    end
    rst = 1'b0;
    do_op(8'h01, 8'h00, "t6_after");
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 3 == 0) ? ra : (i % 3 == 1) ? (ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1))) : WIDTH'($urandom);
      do_op(ra, rb, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
